// File: rtl/nf10_ipif_arbiter.sv
// Two-requester round-robin arbiter in front of a single IPIF register slave.
// Optional WAIT timeout with forced error completion is enabled by defining IPIF_ARB_TIMEOUT_EN.
module nf10_ipif_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES   = 64
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic                              M0_CS,
    input  logic                              M0_RNW,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     M0_ADDR,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     M0_DATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   M0_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     M0_RDATA,
    output logic                              M0_RDACK,
    output logic                              M0_WRACK,
    output logic                              M0_ERROR,
    input  logic                              M1_CS,
    input  logic                              M1_RNW,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     M1_ADDR,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     M1_DATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   M1_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     M1_RDATA,
    output logic                              M1_RDACK,
    output logic                              M1_WRACK,
    output logic                              M1_ERROR,
    output logic                              Bus2IP_CS,
    output logic                              Bus2IP_RNW,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
    input  logic                              IP2Bus_RdAck,
    input  logic                              IP2Bus_WrAck,
    input  logic                              IP2Bus_Error
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int BW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_start;
    logic            w_sel;
    logic            w_finish;
    logic            w_ack;
    logic            w_timeout;

    logic            r_gnt;
    logic            r_rr;
    logic            r_cs;
    logic            r_rnw;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [BW-1:0]   r_be;
    logic            r_rdack;
    logic            r_wrack;
    logic            r_err;
    logic [DW-1:0]   r_rdata;

    // Only an ack matching the latched direction completes the transaction.
    assign w_ack = r_rnw ? IP2Bus_RdAck : IP2Bus_WrAck;

`ifdef IPIF_ARB_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] r_tmo;

    assign w_timeout = (r_state == ST_WAIT) && !w_ack &&
                       (r_tmo == TW'(C_TIMEOUT_CYCLES - 1));

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_tmo <= '0;
        end else if (w_start) begin
            r_tmo <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (C_TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_sel        = r_rr;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (M0_CS || M1_CS) begin
                    w_start      = 1'b1;
                    w_sel        = (M0_CS && M1_CS) ? r_rr : M1_CS;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_gnt   <= 1'b0;
            r_rr    <= 1'b0;
            r_cs    <= 1'b0;
            r_rnw   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_be    <= '0;
            r_rdack <= 1'b0;
            r_wrack <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rdack <= 1'b0;
            r_wrack <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            if (w_start) begin
                r_gnt  <= w_sel;
                r_cs   <= 1'b1;
                r_rnw  <= w_sel ? M1_RNW  : M0_RNW;
                r_addr <= w_sel ? M1_ADDR : M0_ADDR;
                r_data <= w_sel ? M1_DATA : M0_DATA;
                r_be   <= w_sel ? M1_BE   : M0_BE;
            end
            if (w_finish) begin
                r_cs    <= 1'b0;
                r_rdack <= r_rnw;
                r_wrack <= !r_rnw;
                r_err   <= w_timeout ? 1'b1 : IP2Bus_Error;
                r_rdata <= (r_rnw && !w_timeout) ? IP2Bus_Data : '0;
                r_rr    <= !r_gnt;
            end
        end
    end

    // Completion pulses and read data are steered to the granted requester only.
    assign M0_RDACK = r_rdack & !r_gnt;
    assign M0_WRACK = r_wrack & !r_gnt;
    assign M0_ERROR = r_err   & !r_gnt;
    assign M0_RDATA = r_gnt ? '0 : r_rdata;
    assign M1_RDACK = r_rdack & r_gnt;
    assign M1_WRACK = r_wrack & r_gnt;
    assign M1_ERROR = r_err   & r_gnt;
    assign M1_RDATA = r_gnt ? r_rdata : '0;

    assign Bus2IP_CS   = r_cs;
    assign Bus2IP_RNW  = r_rnw;
    assign Bus2IP_Addr = r_addr;
    assign Bus2IP_Data = r_data;
    assign Bus2IP_BE   = r_be;
endmodule
